iopmp_seq_checker: RTL and testbench

- Parametrised, multi-cycle IOPMP permission checker. Walks entries one per cycle in priority order, restricted to the memory domains (MDs) enabled in the requester's SRCMD bitmap.
- Returns allow/deny with the index of the matching entry.
- Captures the first denied transaction in a sticky error record, with a saturating overflow counter.
- Sits between a DMA master port and the IOPMP register file. The register file supplies all configuration as flat vectors.

---
 rtl/iopmp_seq_checker.sv | 206 ++++++++++++++++++++
 tb/tb_iopmp_seq_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/iopmp_seq_checker.sv
// Sequential IOPMP permission checker: one entry per cycle in priority order, filtered by
// the requester's MD bitmap. The first denial is kept in a sticky record with a saturating drop counter.
module iopmp_seq_checker #(
    parameter int NR_ENTRIES = 32,
    parameter int NR_MD      = 63,
    parameter int ADDR_WIDTH = 34,
    parameter int SID_WIDTH  = 14,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [ADDR_WIDTH-1:0]              req_addr_i,
    input  logic [1:0]                         req_access_i,
    input  logic [SID_WIDTH-1:0]               req_sid_i,
    input  logic [NR_MD-1:0]                   srcmd_md_i,
    input  logic [16*NR_MD-1:0]                mdcfg_t_i,
    input  logic [(ADDR_WIDTH-2)*NR_ENTRIES-1:0] entry_addr_i,
    input  logic [8*NR_ENTRIES-1:0]            entry_cfg_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic                               rsp_allow_o,
    output logic                               rsp_hit_o,
    output logic [$clog2(NR_ENTRIES)-1:0]      rsp_entry_o,
    output logic                               rcd_valid_o,
    output logic [ADDR_WIDTH-1:0]              rcd_addr_o,
    output logic [SID_WIDTH-1:0]               rcd_sid_o,
    output logic                               rcd_read_o,
    output logic [CNT_WIDTH-1:0]               rcd_cnt_o,
    input  logic                               rcd_clear_i
);

    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int AW    = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {ACC_NONE, ACC_READ, ACC_WRITE} iopmp_access_t;
    typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} addr_mode_t;
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_t;

    typedef struct packed {
        logic [2:0] rsvd;
        addr_mode_t a;
        logic       x;
        logic       w;
        logic       r;
    } iopmp_entry_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        iopmp_access_t         access;
        logic [SID_WIDTH-1:0]  sid;
        logic [NR_MD-1:0]      md;
    } req_t;

    typedef struct packed {
        logic             allow;
        logic             hit;
        logic [IDX_W-1:0] entry;
    } rsp_t;

    logic         [NR_MD-1:0][15:0]     mdcfg_top;
    logic         [NR_ENTRIES-1:0][AW-1:0] entry_addr;
    iopmp_entry_t [NR_ENTRIES-1:0]      entry_cfg;

    assign mdcfg_top  = mdcfg_t_i;
    assign entry_addr = entry_addr_i;
    assign entry_cfg  = entry_cfg_i;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    req_t             req_q;
    rsp_t             rsp_q, rsp_d;
    logic             req_load, rsp_load, capture;

    iopmp_entry_t     cur_cfg;
    logic [AW-1:0]    e_cur, e_prev, napot_ones, word_addr;
    logic             owned, owner_bit, eligible, match, allow_hit;
    logic             unused_cfg;

    // Ownership goes to the lowest MD whose top bound lies above the current index.
    always_comb begin
        owned     = 1'b0;
        owner_bit = 1'b0;
        for (int m = 0; m < NR_MD; m++) begin
            if (!owned && (16'(idx_q) < mdcfg_top[m])) begin
                owned     = 1'b1;
                owner_bit = req_q.md[m];
            end
        end
        eligible = owned && owner_bit;
    end

    always_comb begin
        cur_cfg    = entry_cfg[idx_q];
        e_cur      = entry_addr[idx_q];
        e_prev     = (idx_q == '0) ? '0 : entry_addr[idx_q - IDX_W'(1)];
        napot_ones = e_cur ^ (e_cur + AW'(1));
        word_addr  = req_q.addr[ADDR_WIDTH-1:2];
        match      = 1'b0;
        case (cur_cfg.a)
            A_TOR:   match = (e_prev < e_cur) && (word_addr >= e_prev) && (word_addr < e_cur);
            A_NA4:   match = (word_addr == e_cur);
            A_NAPOT: match = ((word_addr ^ e_cur) & ~napot_ones) == '0;
            default: match = 1'b0;
        endcase
        case (req_q.access)
            ACC_READ:  allow_hit = cur_cfg.r;
            ACC_WRITE: allow_hit = cur_cfg.w;
            default:   allow_hit = 1'b1;
        endcase
    end

    assign unused_cfg = ^{cur_cfg.rsvd, cur_cfg.x};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rsp_d       = rsp_q;
        req_load    = 1'b0;
        rsp_load    = 1'b0;
        capture     = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    req_load = 1'b1;
                    if (!enable_i) begin
                        state_d  = S_RESP;
                        rsp_load = 1'b1;
                        rsp_d    = '{allow: 1'b1, hit: 1'b0, entry: '0};
                    end else begin
                        state_d = S_WALK;
                        idx_d   = '0;
                    end
                end
            end
            S_WALK: begin
                if (eligible && match) begin
                    state_d  = S_RESP;
                    rsp_load = 1'b1;
                    rsp_d    = '{allow: allow_hit, hit: 1'b1, entry: idx_q};
                    capture  = !allow_hit;
                end else if (idx_q == IDX_W'(NR_ENTRIES - 1)) begin
                    state_d  = S_RESP;
                    rsp_load = 1'b1;
                    rsp_d    = '{allow: 1'b0, hit: 1'b0, entry: '0};
                    capture  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (req_load) req_q <= '{addr: req_addr_i, access: iopmp_access_t'(req_access_i),
                                     sid: req_sid_i, md: srcmd_md_i};
            if (rsp_load) rsp_q <= rsp_d;
        end
    end

    // A clear coinciding with a capture yields a fresh record rather than a drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcd_valid_o <= 1'b0;
            rcd_addr_o  <= '0;
            rcd_sid_o   <= '0;
            rcd_read_o  <= 1'b0;
            rcd_cnt_o   <= '0;
        end else if (capture) begin
            if (!rcd_valid_o || rcd_clear_i) begin
                rcd_valid_o <= 1'b1;
                rcd_addr_o  <= req_q.addr;
                rcd_sid_o   <= req_q.sid;
                rcd_read_o  <= (req_q.access == ACC_READ);
                rcd_cnt_o   <= '0;
            end else if (rcd_cnt_o != '1) begin
                rcd_cnt_o <= rcd_cnt_o + CNT_WIDTH'(1);
            end
        end else if (rcd_clear_i) begin
            rcd_valid_o <= 1'b0;
            rcd_cnt_o   <= '0;
        end
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_allow_o = rsp_q.allow;
    assign rsp_hit_o   = rsp_q.hit;
    assign rsp_entry_o = rsp_q.entry;

endmodule

// File: tb/tb_iopmp_seq_checker.sv
// Directed bench for iopmp_seq_checker: 8 entries, 4 MDs with T={2,4,6,8}.
module tb_iopmp_seq_checker;

    logic              clk = 1'b0;
    logic              rst, enable, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [33:0]       req_addr;
    logic [1:0]        req_access;
    logic [13:0]       req_sid;
    logic [3:0]        srcmd_md;
    logic [3:0][15:0]  mdcfg;
    logic [7:0][31:0]  e_addr;
    logic [7:0][7:0]   e_cfg;
    logic              rsp_allow, rsp_hit, rcd_valid, rcd_read, rcd_clear;
    logic [2:0]        rsp_entry;
    logic [33:0]       rcd_addr;
    logic [13:0]       rcd_sid;
    logic [7:0]        rcd_cnt;
    int                n_cmp = 0;
    int                n_err = 0;
    int                lat;

    localparam logic [1:0] RD = 2'd1, WR = 2'd2;

    always #5 clk = ~clk;

    iopmp_seq_checker #(.NR_ENTRIES(8), .NR_MD(4), .ADDR_WIDTH(34), .SID_WIDTH(14), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_access_i(req_access), .req_sid_i(req_sid), .srcmd_md_i(srcmd_md),
        .mdcfg_t_i(mdcfg), .entry_addr_i(e_addr), .entry_cfg_i(e_cfg),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
        .rsp_hit_o(rsp_hit), .rsp_entry_o(rsp_entry),
        .rcd_valid_o(rcd_valid), .rcd_addr_o(rcd_addr), .rcd_sid_o(rcd_sid),
        .rcd_read_o(rcd_read), .rcd_cnt_o(rcd_cnt), .rcd_clear_i(rcd_clear)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [33:0] addr, input logic [1:0] acc,
                          input logic [13:0] sid, input logic [3:0] md);
        req_addr = addr; req_access = acc; req_sid = sid; srcmd_md = md;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1; bounded so a stuck walk still terminates.
    task automatic do_req(input logic [33:0] addr, input logic [1:0] acc,
                          input logic [13:0] sid, input logic [3:0] md, output int l);
        launch(addr, acc, sid, md);
        l = 1;
        while (!rsp_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; rcd_clear = 1'b0;
        req_addr = '0; req_access = '0; req_sid = '0; srcmd_md = '0;
        mdcfg = {16'd8, 16'd6, 16'd4, 16'd2};
        e_addr = '0; e_cfg = '0;
        repeat (2) tick();
        rst = 1'b0;

        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp", {rsp_valid, rsp_allow, rsp_hit, rsp_entry}, 0);
        chk("reset_rcd", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt}, 0);

        // bypass
        do_req(34'h5000, RD, 14'd1, 4'b0000, lat);
        chk("bypass_lat", lat, 1);
        chk("bypass_allow_hit", {rsp_allow, rsp_hit, rsp_entry}, 5'b10_000);
        chk("bypass_req_ready", req_ready, 0);
        finish_rsp();
        chk("bypass_rcd_valid", rcd_valid, 0);
        chk("bypass_back_idle", req_ready, 1);

        // TOR entry0 [0,0x1000) read-only
        enable = 1'b1;
        e_addr[0] = 32'h400; e_cfg[0] = 8'h09;
        do_req(34'h0FFC, RD, 14'd2, 4'b0001, lat);
        chk("tor_rd_lat", lat, 2);
        chk("tor_rd_rsp", {rsp_allow, rsp_hit, rsp_entry}, 5'b11_000);
        finish_rsp();
        chk("tor_rd_no_rcd", rcd_valid, 0);

        do_req(34'h0FFC, WR, 14'd5, 4'b0001, lat);
        chk("tor_wr_lat", lat, 2);
        chk("tor_wr_rsp", {rsp_allow, rsp_hit, rsp_entry}, 5'b01_000);
        chk("tor_wr_rcd", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt},
            {1'b1, 34'h0FFC, 14'd5, 1'b0, 8'd0});
        finish_rsp();
        rcd_clear = 1'b1; tick(); rcd_clear = 1'b0;
        chk("clear_alone", {rcd_valid, rcd_cnt}, 0);

        // NAPOT entry3 covers 0x40000-0x40FFF, owned by MD1
        e_addr[3] = 32'h101FF; e_cfg[3] = 8'h1B;
        do_req(34'h40FF0, RD, 14'd7, 4'b0001, lat);
        chk("napot_md0_lat", lat, 9);
        chk("napot_md0_rsp", {rsp_allow, rsp_hit, rsp_entry}, 5'b00_000);
        chk("napot_md0_rcd", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt},
            {1'b1, 34'h40FF0, 14'd7, 1'b1, 8'd0});
        finish_rsp();
        do_req(34'h40FF0, RD, 14'd8, 4'b0010, lat);
        chk("napot_md1_lat", lat, 5);
        chk("napot_md1_rsp", {rsp_allow, rsp_hit, rsp_entry}, 5'b11_011);
        chk("napot_md1_rcd_kept", {rcd_addr, rcd_cnt}, {34'h40FF0, 8'd0});
        finish_rsp();
        rcd_clear = 1'b1; tick(); rcd_clear = 1'b0;

        // priority: two NA4 entries on the same word, lower index wins
        e_addr[3] = '0; e_cfg[3] = '0;
        e_addr[0] = 32'h100; e_cfg[0] = 8'h10;
        e_addr[1] = 32'h100; e_cfg[1] = 8'h11;
        do_req(34'h400, RD, 14'd3, 4'b0001, lat);
        chk("prio_lat", lat, 2);
        chk("prio_rsp", {rsp_allow, rsp_hit, rsp_entry}, 5'b01_000);
        finish_rsp();
        rcd_clear = 1'b1; tick(); rcd_clear = 1'b0;

        // sticky record with saturating counter
        do_req(34'h1000, RD, 14'd9, 4'b0000, lat);
        chk("miss_lat", lat, 9);
        finish_rsp();
        do_req(34'h2000, WR, 14'd10, 4'b0000, lat);
        finish_rsp();
        chk("sticky_first", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt},
            {1'b1, 34'h1000, 14'd9, 1'b1, 8'd1});
        for (int i = 0; i < 253; i++) begin
            do_req(34'h2000, RD, 14'd10, 4'b0000, lat);
            finish_rsp();
        end
        chk("cnt_254", rcd_cnt, 254);
        do_req(34'h2000, RD, 14'd10, 4'b0000, lat);
        finish_rsp();
        chk("cnt_255", rcd_cnt, 255);
        for (int i = 0; i < 46; i++) begin
            do_req(34'h2000, RD, 14'd10, 4'b0000, lat);
            finish_rsp();
        end
        chk("cnt_saturated", {rcd_addr, rcd_cnt}, {34'h1000, 8'd255});

        // clear coinciding with the capture edge (9th edge counting accept)
        launch(34'h3000, WR, 14'd11, 4'b0000);
        repeat (7) tick();
        rcd_clear = 1'b1;
        tick();
        rcd_clear = 1'b0;
        chk("clr_cap_rsp_valid", rsp_valid, 1);
        chk("clr_cap_rcd", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt},
            {1'b1, 34'h3000, 14'd11, 1'b0, 8'd0});
        finish_rsp();

        // backpressure
        do_req(34'h400, RD, 14'd12, 4'b0001, lat);
        chk("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {rsp_valid, rsp_allow, rsp_hit, rsp_entry, req_ready}, 7'b1_01_000_0);
        end
        finish_rsp();
        chk("bp_released", {rsp_valid, req_ready}, 2'b01);
        chk("bp_rcd_cnt", {rcd_addr, rcd_cnt}, {34'h3000, 8'd1});

        // reset mid-walk at idx 3
        launch(34'h7000, RD, 14'd13, 4'b0000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_walk_ready", {req_ready, rsp_valid}, 2'b10);
        chk("rst_walk_rcd", {rcd_valid, rcd_addr, rcd_sid, rcd_read, rcd_cnt}, 0);
        rst = 1'b0;
        repeat (8) tick();
        chk("rst_no_late_rsp", {req_ready, rsp_valid}, 2'b10);
        chk("rst_no_late_rcd", {rcd_valid, rcd_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
